// File: rtl/pwm_capture.sv
// Eight-lane PWM high-time/period measurer with per-lane stuck detection.
// Results register two clocks after the synchronised rising edge; no backpressure, upd is a bare strobe.

module pwm_capture_chan #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          upd,
  output logic          stuck
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  logic [1:0]    sync_q, sync_d;
  logic          s_d_q, s_d_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] period_q, period_d;
  logic          upd_q, upd_d;
  logic          stuck_q, stuck_d;
  logic          s;
  logic          rise;

  assign s    = sync_q[1];
  assign rise = s & ~s_d_q;

  always_comb begin
    sync_d    = {sync_q[0], pwm_in};
    s_d_d     = s;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    armed_d   = armed_q;
    duty_d    = duty_q;
    period_d  = period_q;
    upd_d     = 1'b0;
    stuck_d   = stuck_q;

    if (rise) begin
      per_cnt_d = CNT_ONE;
      hi_cnt_d  = CNT_ONE;
      if (armed_q) begin
        duty_d   = hi_cnt_q;
        period_d = per_cnt_q;
        upd_d    = 1'b1;
      end
      armed_d = 1'b1;
      stuck_d = 1'b0;
    end else begin
      if (per_cnt_q != CNT_MAX) begin
        per_cnt_d = per_cnt_q + CNT_ONE;
      end
      if (s && (hi_cnt_q != CNT_MAX)) begin
        hi_cnt_d = hi_cnt_q + CNT_ONE;
      end
      // Fires once, on the step into saturation; afterwards everything holds.
      if (per_cnt_q == CNT_PRE) begin
        stuck_d  = 1'b1;
        armed_d  = 1'b0;
        period_d = CNT_MAX;
        duty_d   = s ? CNT_MAX : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      s_d_q     <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      armed_q   <= 1'b0;
      duty_q    <= '0;
      period_q  <= '0;
      upd_q     <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      s_d_q     <= s_d_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      armed_q   <= armed_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      upd_q     <= upd_d;
      stuck_q   <= stuck_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign upd    = upd_q;
  assign stuck  = stuck_q;

endmodule

module pwm_capture #(
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      pwm,
  output logic [8*CW-1:0] duty,
  output logic [8*CW-1:0] period,
  output logic [7:0]      upd,
  output logic [7:0]      stuck
);

  for (genvar i = 0; i < 8; i++) begin : g_chan
    pwm_capture_chan #(
      .CW(CW)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .pwm_in(pwm[i]),
      .duty  (duty[i*CW +: CW]),
      .period(period[i*CW +: CW]),
      .upd   (upd[i]),
      .stuck (stuck[i])
    );
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: lanes are driven from per-lane high/low patterns on the falling edge,
// and every expected (duty, period) pair is queued at the driven rise and matched against upd.
`timescale 1ns/1ps

module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int MAXV = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      pwm;
  logic [8*CW-1:0] duty;
  logic [8*CW-1:0] period;
  logic [7:0]      upd;
  logic [7:0]      stuck;

  always #5 clk = ~clk;

  pwm_capture #(.CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .pwm   (pwm),
    .duty  (duty),
    .period(period),
    .upd   (upd),
    .stuck (stuck)
  );

  int checks   = 0;
  int failures = 0;

  int  hi_len[8];
  int  lo_len[8];
  int  ph[8];
  bit  run_en[8];
  bit  hold_lvl[8];
  bit  prev_lvl[8];
  bit  m_armed[8];
  int  m_c[8];
  int  m_hi[8];
  int  upd_seen[8];
  int  stuck_hi[8];
  logic [15:0] exp_q[8][$];
  logic [15:0] mon_exp;
  logic [15:0] mon_got;

  function automatic logic [CW-1:0] lane_of(input logic [8*CW-1:0] bus, input int i);
    return bus[i*CW +: CW];
  endfunction

  // Scoreboard consumer: every upd pulse must match the oldest queued measurement of its lane.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        if (upd[i]) begin
          upd_seen[i]++;
          checks++;
          mon_got = {lane_of(duty, i), lane_of(period, i)};
          if (exp_q[i].size() == 0) begin
            failures++;
            $display("FAIL upd_unexpected lane=%0d got duty=%0d period=%0d, required no update",
                     i, mon_got[15:8], mon_got[7:0]);
          end else begin
            mon_exp = exp_q[i].pop_front();
            if (mon_got !== mon_exp) begin
              failures++;
              $display("FAIL upd_value lane=%0d got duty=%0d period=%0d, required duty=%0d period=%0d",
                       i, mon_got[15:8], mon_got[7:0], mon_exp[15:8], mon_exp[7:0]);
            end
          end
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_armed[i] = 1'b0;
      m_c[i]     = 0;
      m_hi[i]    = 0;
      upd_seen[i] = 0;
      stuck_hi[i] = 0;
      exp_q[i].delete();
    end
  endtask

  task automatic set_lane(input int i, input int hi, input int lo);
    hi_len[i] = hi;
    lo_len[i] = lo;
    ph[i]     = 0;
    run_en[i] = 1'b1;
  endtask

  task automatic stop_all();
    for (int i = 0; i < 8; i++) begin
      run_en[i]   = 1'b0;
      hold_lvl[i] = 1'b0;
    end
  endtask

  // One call step = one falling edge: drive every lane and queue measurements at pin-level rises.
  task automatic run_cycles(input int n);
    bit lvl;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (!rst && stuck[i]) stuck_hi[i]++;
        if (run_en[i]) begin
          lvl   = (ph[i] < hi_len[i]);
          ph[i] = (ph[i] + 1) % (hi_len[i] + lo_len[i]);
        end else begin
          lvl = hold_lvl[i];
        end
        if (rst) begin
          m_armed[i] = 1'b0;
          m_c[i]     = 0;
          m_hi[i]    = 0;
          exp_q[i].delete();
        end else if (lvl && !prev_lvl[i]) begin
          if (m_armed[i]) exp_q[i].push_back({8'(m_hi[i]), 8'(m_c[i])});
          m_armed[i] = 1'b1;
          m_c[i]     = 1;
          m_hi[i]    = 1;
        end else begin
          if (m_c[i] == MAXV - 1) m_armed[i] = 1'b0;
          if (m_c[i] < MAXV) m_c[i]++;
          if (lvl && m_hi[i] < MAXV) m_hi[i]++;
        end
        prev_lvl[i] = lvl;
        pwm[i]      = lvl;
      end
    end
  endtask

  task automatic do_reset();
    stop_all();
    rst = 1'b1;
    run_cycles(3);
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int total;
    stop_all();
    rst = 1'b1;
    run_cycles(2);
    checks++; if (duty !== '0)   begin failures++; $display("FAIL reset_duty got=%h required=0", duty); end
    checks++; if (period !== '0) begin failures++; $display("FAIL reset_period got=%h required=0", period); end
    checks++; if (upd !== '0)    begin failures++; $display("FAIL reset_upd got=%h required=0", upd); end
    checks++; if (stuck !== '0)  begin failures++; $display("FAIL reset_stuck got=%h required=0", stuck); end
    rst = 1'b0;
    model_clear();
    set_lane(0, 3, 5);
    set_lane(4, 2, 2);
    run_cycles(30);
    checks++; if (lane_of(duty, 4) !== 8'd2) begin failures++; $display("FAIL pre_reset_duty4 got=%0d required=2", lane_of(duty, 4)); end
    // Asynchronous assertion between edges while lanes keep toggling.
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    checks++; if (duty !== '0)   begin failures++; $display("FAIL async_reset_duty got=%h required=0", duty); end
    checks++; if (period !== '0) begin failures++; $display("FAIL async_reset_period got=%h required=0", period); end
    checks++; if (upd !== '0)    begin failures++; $display("FAIL async_reset_upd got=%h required=0", upd); end
    checks++; if (stuck !== '0)  begin failures++; $display("FAIL async_reset_stuck got=%h required=0", stuck); end
    run_cycles(5);
    checks++; if (duty !== '0) begin failures++; $display("FAIL in_reset_duty got=%h required=0", duty); end
    stop_all();
    run_cycles(3);
    rst = 1'b0;
    model_clear();
    set_lane(0, 3, 5);
    set_lane(4, 2, 2);
    run_cycles(6);
    checks++; if (upd_seen[4] !== 0) begin failures++; $display("FAIL rearm_lane4_early got=%0d required=0", upd_seen[4]); end
    run_cycles(4);
    checks++; if (upd_seen[0] !== 0) begin failures++; $display("FAIL rearm_lane0_early got=%0d required=0", upd_seen[0]); end
    checks++; if (upd_seen[4] !== 1) begin failures++; $display("FAIL rearm_lane4_first got=%0d required=1", upd_seen[4]); end
    run_cycles(4);
    checks++; if (upd_seen[0] !== 1) begin failures++; $display("FAIL rearm_lane0_first got=%0d required=1", upd_seen[0]); end
    stop_all();
    run_cycles(5);
    total = 0;
    for (int i = 0; i < 8; i++) total += exp_q[i].size();
    checks++; if (total !== 0) begin failures++; $display("FAIL reset_drain pending=%0d required=0", total); end
  endtask

  task automatic test_periodic();
    do_reset();
    set_lane(0, 3, 5);
    run_cycles(12);
    checks++; if (upd_seen[0] !== 1) begin failures++; $display("FAIL periodic_first_count got=%0d required=1", upd_seen[0]); end
    checks++; if (lane_of(duty, 0) !== 8'd3)   begin failures++; $display("FAIL periodic_duty got=%0d required=3", lane_of(duty, 0)); end
    checks++; if (lane_of(period, 0) !== 8'd8) begin failures++; $display("FAIL periodic_period got=%0d required=8", lane_of(period, 0)); end
    run_cycles(36);
    stop_all();
    run_cycles(5);
    checks++; if (upd_seen[0] !== 5) begin failures++; $display("FAIL periodic_count got=%0d required=5", upd_seen[0]); end
    checks++; if (exp_q[0].size() !== 0) begin failures++; $display("FAIL periodic_pending got=%0d required=0", exp_q[0].size()); end
  endtask

  task automatic test_independence();
    int others;
    do_reset();
    set_lane(0, 3, 5);
    set_lane(3, 1, 1);
    set_lane(5, 7, 1);
    run_cycles(64);
    stop_all();
    run_cycles(5);
    checks++; if (upd_seen[3] !== 31) begin failures++; $display("FAIL indep_count3 got=%0d required=31", upd_seen[3]); end
    checks++; if (upd_seen[5] !== 7)  begin failures++; $display("FAIL indep_count5 got=%0d required=7", upd_seen[5]); end
    checks++; if (upd_seen[0] !== 7)  begin failures++; $display("FAIL indep_count0 got=%0d required=7", upd_seen[0]); end
    others = upd_seen[1] + upd_seen[2] + upd_seen[4] + upd_seen[6] + upd_seen[7];
    checks++; if (others !== 0) begin failures++; $display("FAIL indep_crosstalk got=%0d required=0", others); end
    checks++; if (lane_of(duty, 3) !== 8'd1)   begin failures++; $display("FAIL indep_duty3 got=%0d required=1", lane_of(duty, 3)); end
    checks++; if (lane_of(period, 3) !== 8'd2) begin failures++; $display("FAIL indep_period3 got=%0d required=2", lane_of(period, 3)); end
    checks++; if (lane_of(duty, 5) !== 8'd7)   begin failures++; $display("FAIL indep_duty5 got=%0d required=7", lane_of(duty, 5)); end
    checks++; if (lane_of(period, 5) !== 8'd8) begin failures++; $display("FAIL indep_period5 got=%0d required=8", lane_of(period, 5)); end
  endtask

  task automatic test_stuck_low();
    do_reset();
    run_cycles(250);
    checks++; if (stuck[2] !== 1'b0) begin failures++; $display("FAIL stuck_low_early got=%0b required=0", stuck[2]); end
    run_cycles(10);
    checks++; if (stuck[2] !== 1'b1) begin failures++; $display("FAIL stuck_low_set got=%0b required=1", stuck[2]); end
    checks++; if (lane_of(duty, 2) !== 8'd0)     begin failures++; $display("FAIL stuck_low_duty got=%0d required=0", lane_of(duty, 2)); end
    checks++; if (lane_of(period, 2) !== 8'd255) begin failures++; $display("FAIL stuck_low_period got=%0d required=255", lane_of(period, 2)); end
    set_lane(2, 4, 6);
    run_cycles(4);
    checks++; if (stuck[2] !== 1'b0) begin failures++; $display("FAIL stuck_low_clear got=%0b required=0", stuck[2]); end
    checks++; if (upd_seen[2] !== 0) begin failures++; $display("FAIL stuck_low_first_rise got=%0d required=0", upd_seen[2]); end
    run_cycles(26);
    stop_all();
    run_cycles(5);
    checks++; if (upd_seen[2] !== 2) begin failures++; $display("FAIL stuck_low_resume got=%0d required=2", upd_seen[2]); end
    checks++; if (lane_of(duty, 2) !== 8'd4)    begin failures++; $display("FAIL stuck_low_rduty got=%0d required=4", lane_of(duty, 2)); end
    checks++; if (lane_of(period, 2) !== 8'd10) begin failures++; $display("FAIL stuck_low_rperiod got=%0d required=10", lane_of(period, 2)); end
  endtask

  task automatic test_stuck_high();
    do_reset();
    hold_lvl[7] = 1'b1;
    run_cycles(250);
    checks++; if (stuck[7] !== 1'b0) begin failures++; $display("FAIL stuck_high_early got=%0b required=0", stuck[7]); end
    run_cycles(10);
    checks++; if (stuck[7] !== 1'b1) begin failures++; $display("FAIL stuck_high_set got=%0b required=1", stuck[7]); end
    checks++; if (lane_of(duty, 7) !== 8'd255)   begin failures++; $display("FAIL stuck_high_duty got=%0d required=255", lane_of(duty, 7)); end
    checks++; if (lane_of(period, 7) !== 8'd255) begin failures++; $display("FAIL stuck_high_period got=%0d required=255", lane_of(period, 7)); end
    run_cycles(40);
    checks++; if (lane_of(duty, 7) !== 8'd255) begin failures++; $display("FAIL stuck_high_hold got=%0d required=255", lane_of(duty, 7)); end
    checks++; if (upd_seen[7] !== 0) begin failures++; $display("FAIL stuck_high_upd got=%0d required=0", upd_seen[7]); end
    hold_lvl[7] = 1'b0;
    run_cycles(5);
  endtask

  task automatic test_boundary();
    do_reset();
    set_lane(1, 1, 253);
    run_cycles(763);
    stop_all();
    run_cycles(5);
    checks++; if (upd_seen[1] !== 3) begin failures++; $display("FAIL bound254_count got=%0d required=3", upd_seen[1]); end
    checks++; if (stuck_hi[1] !== 0) begin failures++; $display("FAIL bound254_stuck got=%0d cycles required=0", stuck_hi[1]); end
    checks++; if (lane_of(duty, 1) !== 8'd1)     begin failures++; $display("FAIL bound254_duty got=%0d required=1", lane_of(duty, 1)); end
    checks++; if (lane_of(period, 1) !== 8'd254) begin failures++; $display("FAIL bound254_period got=%0d required=254", lane_of(period, 1)); end

    do_reset();
    set_lane(1, 1, 254);
    run_cycles(1);
    run_cycles(255);
    checks++; if (stuck[1] !== 1'b0) begin failures++; $display("FAIL bound255_pre1 got=%0b required=0", stuck[1]); end
    run_cycles(1);
    checks++; if (stuck[1] !== 1'b0) begin failures++; $display("FAIL bound255_pre0 got=%0b required=0", stuck[1]); end
    run_cycles(1);
    checks++; if (stuck[1] !== 1'b1) begin failures++; $display("FAIL bound255_hit got=%0b required=1", stuck[1]); end
    checks++; if (lane_of(period, 1) !== 8'd255) begin failures++; $display("FAIL bound255_period got=%0d required=255", lane_of(period, 1)); end
    checks++; if (lane_of(duty, 1) !== 8'd0)     begin failures++; $display("FAIL bound255_duty got=%0d required=0", lane_of(duty, 1)); end
    run_cycles(1);
    checks++; if (stuck[1] !== 1'b0) begin failures++; $display("FAIL bound255_clear got=%0b required=0", stuck[1]); end
    stop_all();
    run_cycles(5);
    checks++; if (upd_seen[1] !== 0) begin failures++; $display("FAIL bound255_upd got=%0d required=0", upd_seen[1]); end
  endtask

  initial begin
    rst = 1'b1;
    pwm = '0;
    for (int i = 0; i < 8; i++) begin
      prev_lvl[i] = 1'b0;
      hi_len[i]   = 1;
      lo_len[i]   = 1;
      ph[i]       = 0;
    end
    stop_all();
    model_clear();
    test_reset();
    test_periodic();
    test_independence();
    test_stuck_low();
    test_stuck_high();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Eight-channel PWM duty-cycle and period measurer: the receive-side counterpart to the 8-bit PWM generator. It samples an 8-lane PWM bus, synchronises each lane, and measures high time and period in clock cycles between consecutive rising edges. It publishes per-channel results with an update strobe and a stuck-line flag. It sits between the PWM bus (external pins or the on-chip generator) and monitoring or control logic.

## Interface
- CW, 8: counter and result width per channel. Results saturate at 2^CW-1.
- clk  input  1  system clock; all logic is on its rising edge
- rst  input  1  asynchronous, active-high reset
- pwm  input  8  PWM lanes, asynchronous to clk; bit i is channel i
- duty  output  8*CW  high-time results; channel i is duty[i*CW +: CW]
- period  output  8*CW  period results; channel i is period[i*CW +: CW]
- upd  output  8  one-cycle pulse: channel i's duty/period were just updated with a valid measurement
- stuck  output  8  level: channel i has had no rising edge for 2^CW-1 cycles

## Operation
Channels are independent and identical. Per channel i:
- **Synchroniser:** a 2-flop synchroniser produces s. A further register s_d holds the previous s. rise = s & ~s_d.
- **Counters:** per_cnt and hi_cnt, each CW bits. armed is a 1-bit register.
- **On a rise cycle:**
  - per_cnt <= 1 and hi_cnt <= 1.
  - If armed=1: duty <= hi_cnt, period <= per_cnt, upd pulses.
  - If armed=0: no result update and no upd pulse.
  - armed <= 1 and stuck <= 0.
- **Otherwise:**
  - per_cnt increments, saturating at 2^CW-1.
  - hi_cnt increments only when s=1, saturating at 2^CW-1.
- **Stuck detection:** on the cycle per_cnt increments to 2^CW-1 with no rise:
  - stuck <= 1 and armed <= 0.
  - period <= 2^CW-1.
  - duty <= (s ? 2^CW-1 : 0).
  - No upd pulse.
  - While saturated, outputs hold.
- **Measurement meaning:** at a rise, per_cnt equals the number of cycles since the previous rise, i.e. the period. hi_cnt equals the number of those cycles with s=1.
- **Limits:**
  - Minimum measurable period is 2 (one high, one low synchronised cycle).
  - Periods of 2^CW-1 or more are reported as stuck, not as a measurement.
- **Simultaneous rise and saturation:** the rise wins. The measurement is taken if armed, and stuck stays 0.
- **First rise after reset or after stuck:** arms the channel only. The first upd comes at the second rise.

## Timing
- **Reset values:** duty=0, period=0, upd=0, stuck=0. Synchroniser flops, s_d, counters and armed are all 0.
- **Reset mid-measurement:** discards all state. The channel needs two rises after release before the next upd.
- **Rise latency:** a pwm rising edge set up before clk edge k is seen as rise in the cycle after edge k+1.
  - duty, period and upd register at edge k+2.
  - upd is high for exactly one cycle after edge k+2.
- **Result stability:** duty and period change only when upd pulses or stuck asserts. They are otherwise stable for any number of cycles.
- **Input filtering:** pulses shorter than one clk period may be missed. No glitch filtering beyond synchronisation.

## Test plan
- **Reset state:** assert rst asynchronously mid-cycle, with lanes toggling.
  - All outputs go to 0 immediately.
  - After release, upd stays 0 until each active lane's second rise.
- **Periodic measurement:** CW=8, lane 0 repeats 3 cycles high and 5 cycles low.
  - At the second rise, upd[0] pulses and duty[7:0]=3, period[7:0]=8.
  - Every later rise repeats the same values, with upd[0] high for exactly 1 cycle each time.
- **Extreme duty and independence:**
  - Lane 3 at 1 high / 1 low gives duty=1, period=2.
  - Lane 5 at 7 high / 1 low gives duty=7, period=8.
  - Results are correct concurrently, with no crosstalk into other lanes' upd.
- **Stuck low:** lane 2 held 0 from reset.
  - At per_cnt=255, stuck[2]=1, duty=0, period=255, and upd[2] never pulses.
  - The first rise clears stuck[2] without an upd.
  - The second rise produces a valid measurement.
- **Stuck high:** lane 7 rises once and then stays 1.
  - When per_cnt reaches 255, stuck[7]=1, duty=255, period=255.
- **Boundary:** lane 1 uses period 254 (1 high).
  - Expect upd with duty=1, period=254 and stuck never set.
  - Repeat with period 255: stuck asserts the cycle the count hits 255, and the next rise produces no upd.
